// File: rtl/pc_with_adder_4.sv
// ============================================================================
// Module   : pc_with_adder_4
// Brief    : 32-bit PC with +4 incrementer indexing a 32 x XLEN register file
//            (x0 hardwired to zero). Optional macro: RF_BYPASS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_with_adder_4 #(
   parameter int          XLEN     = 32,
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter int          PC_INC   = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rg_wrt_en,
   input  logic [XLEN-1:0] write_data,
   output logic [XLEN-1:0] rg_rd_data1,
   output logic [XLEN-1:0] rg_rd_data2
);

   localparam logic [31:0] c_PC_INC = 32'(PC_INC);

   logic [31:0]     pc_q;
   logic [31:0]     pc_d;
   logic [XLEN-1:0] regs_q [32];

   logic [4:0]      w_idx;
   logic [4:0]      w_rs2;
   logic            w_wr;
   logic [XLEN-1:0] w_rf1;
   logic [XLEN-1:0] w_rf2;

   assign pc_d  = pc_q + c_PC_INC;
   assign w_idx = pc_q[6:2];
   assign w_rs2 = w_idx + 5'd1;
   assign w_wr  = rg_wrt_en && (w_idx != 5'd0);

   // Index 0 is forced to zero on read so x0 never needs write protection alone.
   assign w_rf1 = (w_idx == 5'd0) ? '0 : regs_q[w_idx];
   assign w_rf2 = (w_rs2 == 5'd0) ? '0 : regs_q[w_rs2];

`ifdef RF_BYPASS_EN
   assign rg_rd_data1 = w_wr ? write_data : w_rf1;
   assign rg_rd_data2 = (w_wr && (w_rs2 == w_idx)) ? write_data : w_rf2;
`else
   assign rg_rd_data1 = w_rf1;
   assign rg_rd_data2 = w_rf2;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q <= RESET_PC;
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         pc_q <= pc_d;
         if (w_wr) begin
            regs_q[w_idx] <= write_data;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pc_with_adder_4.sv
// ============================================================================
// Module   : tb_pc_with_adder_4
// Brief    : Directed self-checking bench for pc_with_adder_4.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pc_with_adder_4;

   logic        clk;
   logic        reset;
   logic        rg_wrt_en;
   logic [31:0] write_data;
   logic [31:0] rg_rd_data1;
   logic [31:0] rg_rd_data2;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] m_regs [32];
   int          m_idx;

   pc_with_adder_4 dut (
      .clk         (clk),
      .reset       (reset),
      .rg_wrt_en   (rg_wrt_en),
      .write_data  (write_data),
      .rg_rd_data1 (rg_rd_data1),
      .rg_rd_data2 (rg_rd_data2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock edge, updating the reference model with the driven inputs.
   task automatic step();
      if (reset !== 1'b1) begin
         for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
         m_idx = 0;
      end else begin
         if (rg_wrt_en === 1'b1 && m_idx != 0) m_regs[m_idx] = write_data;
         m_idx = (m_idx + 1) % 32;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_rd1"}, rg_rd_data1, (m_idx == 0) ? 32'h0 : m_regs[m_idx]);
      chk({tag, "_rd2"}, rg_rd_data2, (((m_idx + 1) % 32) == 0) ? 32'h0 : m_regs[(m_idx + 1) % 32]);
   endtask

   logic [31:0] bypass_exp;

   initial begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'hFFFF_FFFF;
      m_idx = 0;

      // Reset with X on write controls.
      reset      = 1'b0;
      rg_wrt_en  = 1'bx;
      write_data = 'x;
      @(negedge clk);
      step();
      chk("reset_rd1", rg_rd_data1, 32'h0);
      chk("reset_rd2", rg_rd_data2, 32'h0);

      // x0 write is discarded.
      reset      = 1'b1;
      rg_wrt_en  = 1'b1;
      write_data = 32'h1;
      chk("x0_pre_rd1", rg_rd_data1, 32'h0);
      step();
      chk("idx1_rd1", rg_rd_data1, 32'h0);

      // Write x1, then come back round to idx 0.
      write_data = 32'h1234_5678;
`ifdef RF_BYPASS_EN
      bypass_exp = 32'h1234_5678;
`else
      bypass_exp = 32'h0;
`endif
      chk("x1_pre_rd1", rg_rd_data1, bypass_exp);
      step();
      rg_wrt_en = 1'b0;
      chk("idx2_rd1", rg_rd_data1, 32'h0);
      chk("idx2_rd2", rg_rd_data2, 32'h0);
      for (int i = 0; i < 30; i++) step();
      chk("wrap_idx0_rd1", rg_rd_data1, 32'h0);
      chk("wrap_idx0_rd2", rg_rd_data2, 32'h1234_5678);
      step();
      chk("wrap_idx1_rd1", rg_rd_data1, 32'h1234_5678);
      chk("wrap_idx1_rd2", rg_rd_data2, 32'h0);

      // Reset, then disabled writes for a full sweep read all zero.
      reset = 1'b0;
      step();
      reset      = 1'b1;
      write_data = 32'hDEAD_BEEF;
      for (int i = 0; i < 32; i++) begin
         chk("dis_rd1", rg_rd_data1, 32'h0);
         chk("dis_rd2", rg_rd_data2, 32'h0);
         step();
      end

      // Fill x1..x31 with A5A5_0000 + idx.
      rg_wrt_en = 1'b1;
      for (int i = 0; i < 32; i++) begin
         write_data = 32'hA5A5_0000 + 32'(i);
`ifdef RF_BYPASS_EN
         bypass_exp = (i == 0) ? 32'h0 : write_data;
`else
         bypass_exp = 32'h0;
`endif
         chk("fill_rd1", rg_rd_data1, bypass_exp);
         chk("fill_rd2", rg_rd_data2, 32'h0);
         step();
      end
      rg_wrt_en = 1'b0;
      chk("fill_idx0_rd2", rg_rd_data2, 32'hA5A5_0001);
      for (int i = 0; i < 32; i++) begin
         chk_model("sweep");
         step();
      end
      // Reaching idx 31: rs2 must wrap to x0.
      for (int i = 0; i < 31; i++) step();
      chk("idx31_rd1", rg_rd_data1, 32'hA5A5_001F);
      chk("idx31_rd2", rg_rd_data2, 32'h0);

      // Mid-run reset dominates a concurrent write.
      reset      = 1'b0;
      rg_wrt_en  = 1'b1;
      write_data = 32'hFFFF_FFFF;
      step();
      reset     = 1'b1;
      rg_wrt_en = 1'b0;
      for (int i = 0; i < 32; i++) begin
         chk("post_rst_rd1", rg_rd_data1, 32'h0);
         chk("post_rst_rd2", rg_rd_data2, 32'h0);
         step();
      end

      // Write at idx 5; same-cycle visibility depends on bypass build.
      for (int i = 0; i < 5; i++) step();
      rg_wrt_en  = 1'b1;
      write_data = 32'hCAFE_F00D;
`ifdef RF_BYPASS_EN
      bypass_exp = 32'hCAFE_F00D;
`else
      bypass_exp = 32'h0;
`endif
      chk("idx5_pre_rd1", rg_rd_data1, bypass_exp);
      step();
      rg_wrt_en = 1'b0;
      chk("idx6_rd1", rg_rd_data1, 32'h0);
      for (int i = 0; i < 30; i++) step();
      chk("idx4_rd2", rg_rd_data2, 32'hCAFE_F00D);
      step();
      chk("idx5_rd1", rg_rd_data1, 32'hCAFE_F00D);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
